// File: rtl/timer_pkg.sv
// ---------------------------------------------------------------------------
// timer_pkg
// Shared definitions for the memory-mapped countdown timer (timer_dev):
// FSM state encoding, register word offsets, CTRL field positions, MODE
// values and a byte-lane merge helper used by the register write path.
// ---------------------------------------------------------------------------
package timer_pkg;

  // Counting FSM states
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_CNT  = 2'd2,
    ST_INT  = 2'd3
  } state_e;

  // Register word offsets (addr[3:2]); offset 3 is reserved
  localparam logic [1:0] CTRL_OFS   = 2'd0;
  localparam logic [1:0] PRESET_OFS = 2'd1;
  localparam logic [1:0] COUNT_OFS  = 2'd2;

  // CTRL field positions
  localparam int CTRL_EN_BIT   = 0;
  localparam int CTRL_MODE_LSB = 1;
  localparam int CTRL_MODE_MSB = 2;
  localparam int CTRL_IM_BIT   = 3;

  // MODE values; 2'b1x behaves as one-shot
  localparam logic [1:0] MODE_ONESHOT = 2'b00;
  localparam logic [1:0] MODE_RELOAD  = 2'b01;

  // Replace the bits of old_val selected by mask with the bits of new_val
  function automatic logic [31:0] merge_bytes(input logic [31:0] old_val,
                                              input logic [31:0] new_val,
                                              input logic [31:0] mask);
    return (old_val & ~mask) | (new_val & mask);
  endfunction

endpackage

// File: rtl/timer_dev.sv
// ---------------------------------------------------------------------------
// timer_dev
// Memory-mapped countdown timer on the CPU data bus. Three registers in a
// 16-byte window at BASE_ADDR: CTRL (EN, MODE, IM), PRESET (r/w) and COUNT
// (read-only). A four-state FSM (IDLE/LOAD/CNT/INT) counts COUNT down to
// zero and raises int_flag; irq = CTRL.IM & int_flag.
//
// Ports:
//   clk     in   system clock
//   reset   in   synchronous active-high reset
//   addr    in   byte address (word aligned, addr[1:0] ignored)
//   byteen  in   byte write enables, nonzero = write
//   wdata   in   write data, already lane-shifted
//   rdata   out  combinational read data of the addressed register
//   irq     out  interrupt request
//
// Build option: TIMER_BYTEEN_EN
//   defined   - partial writes merge per byte lane; a CTRL write clears
//               int_flag only when byteen[0] is set.
//   undefined - only byteen == 4'b1111 writes; other nonzero patterns are
//               ignored entirely.
// ---------------------------------------------------------------------------
module timer_dev
  import timer_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0000_7F00
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] addr,
  input  logic [3:0]  byteen,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        irq
);

  logic [3:0]  ctrl_q,     ctrl_d;
  logic [31:0] preset_q,   preset_d;
  logic [31:0] count_q,    count_d;
  logic        int_flag_q, int_flag_d;
  state_e      state_q,    state_d;

  logic        hit;
  logic        wr_ok;
  logic [31:0] wr_mask;
  logic        ctrl_wr;
  logic        preset_wr;
  logic        flag_clr;
  logic [31:0] ctrl_merged;
  logic [3:0]  ctrl_fsm;
  logic        int_flag_fsm;
  logic        unused_ok;

  assign hit       = (addr[31:4] == BASE_ADDR[31:4]);
  assign ctrl_wr   = wr_ok && (addr[3:2] == CTRL_OFS);
  assign preset_wr = wr_ok && (addr[3:2] == PRESET_OFS);

`ifdef TIMER_BYTEEN_EN
  assign wr_ok    = hit && (byteen != 4'b0000);
  assign wr_mask  = {{8{byteen[3]}}, {8{byteen[2]}}, {8{byteen[1]}}, {8{byteen[0]}}};
  // Only a write touching the lane that holds EN/MODE/IM acknowledges the flag
  assign flag_clr = ctrl_wr && byteen[0];
`else
  assign wr_ok    = hit && (byteen == 4'b1111);
  assign wr_mask  = 32'hFFFF_FFFF;
  assign flag_clr = ctrl_wr;
`endif

  assign ctrl_merged = merge_bytes({28'd0, ctrl_q}, wdata, wr_mask);
  assign unused_ok   = &{1'b0, addr[1:0], ctrl_merged[31:4]};

  // Next-state logic: FSM first, then bus writes override CTRL/PRESET and flag
  always_comb begin
    ctrl_fsm     = ctrl_q;
    int_flag_fsm = int_flag_q;
    count_d      = count_q;
    state_d      = state_q;
    case (state_q)
      ST_IDLE: begin
        if (ctrl_q[CTRL_EN_BIT]) state_d = ST_LOAD;
        else                     state_d = ST_IDLE;
      end
      ST_LOAD: begin
        count_d = preset_q;
        state_d = ST_CNT;
      end
      ST_CNT: begin
        if (!ctrl_q[CTRL_EN_BIT]) begin
          state_d = ST_IDLE;
        end else if (count_q == 32'd0) begin
          state_d      = ST_INT;
          int_flag_fsm = 1'b1;
        end else begin
          count_d = count_q - 32'd1;
        end
      end
      ST_INT: begin
        if (ctrl_q[CTRL_MODE_MSB:CTRL_MODE_LSB] == MODE_RELOAD) begin
          // Auto-reload: flag lives for exactly the INT cycle
          state_d      = ST_LOAD;
          int_flag_fsm = 1'b0;
        end else begin
          ctrl_fsm[CTRL_EN_BIT] = 1'b0;
          state_d               = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // A bus write to CTRL wins over the FSM clearing EN in the same cycle
    ctrl_d     = ctrl_wr   ? ctrl_merged[3:0] : ctrl_fsm;
    preset_d   = preset_wr ? merge_bytes(preset_q, wdata, wr_mask) : preset_q;
    int_flag_d = flag_clr  ? 1'b0 : int_flag_fsm;
  end

  // State and register flops with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      ctrl_q     <= 4'd0;
      preset_q   <= 32'd0;
      count_q    <= 32'd0;
      int_flag_q <= 1'b0;
      state_q    <= ST_IDLE;
    end else begin
      ctrl_q     <= ctrl_d;
      preset_q   <= preset_d;
      count_q    <= count_d;
      int_flag_q <= int_flag_d;
      state_q    <= state_d;
    end
  end

  // Zero-latency read mux; misses and the reserved offset read zero
  always_comb begin
    rdata = 32'd0;
    if (hit) begin
      case (addr[3:2])
        CTRL_OFS:   rdata = {28'd0, ctrl_q};
        PRESET_OFS: rdata = preset_q;
        COUNT_OFS:  rdata = count_q;
        default:    rdata = 32'd0;
      endcase
    end else begin
      rdata = 32'd0;
    end
  end

  assign irq = ctrl_q[CTRL_IM_BIT] & int_flag_q;

endmodule

// File: tb/tb_timer_dev.sv
// ---------------------------------------------------------------------------
// tb_timer_dev
// Directed bench for timer_dev. Each stimulus step may push an expected
// rdata and/or irq value into a scoreboard queue; a monitor on the falling
// clock edge pops and compares whenever a step flags a sample.
// ---------------------------------------------------------------------------
module tb_timer_dev;

  localparam logic [31:0] A_CTRL = 32'h0000_7F00;
  localparam logic [31:0] A_PRE  = 32'h0000_7F04;
  localparam logic [31:0] A_CNT  = 32'h0000_7F08;
  localparam logic [31:0] A_RSV  = 32'h0000_7F0C;
  localparam logic [3:0]  BE_ALL = 4'b1111;

`ifdef TIMER_BYTEEN_EN
  localparam logic [31:0] PARTIAL_PRE = 32'h0000_CCDD;
  localparam logic [31:0] LANE0_CTRL  = 32'h0000_0000;
  localparam logic        LANE0_IRQ   = 1'b0;
`else
  localparam logic [31:0] PARTIAL_PRE = 32'h0000_0000;
  localparam logic [31:0] LANE0_CTRL  = 32'h0000_0008;
  localparam logic        LANE0_IRQ   = 1'b1;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] addr;
  logic [3:0]  byteen;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        irq;

  typedef struct {
    logic [31:0] exp_rd;
    logic        exp_irq;
    logic        do_rd;
    logic        do_irq;
    int          tag;
  } sb_t;

  sb_t  sb_q[$];
  sb_t  mon_e;
  logic chk_valid = 1'b0;
  int   checks = 0;
  int   failures = 0;

  logic [31:0] ar_cnt [0:12] = '{32'd0, 32'd0, 32'd2, 32'd1, 32'd0, 32'd0, 32'd0,
                                 32'd2, 32'd1, 32'd0, 32'd0, 32'd0, 32'd2};
  logic [31:0] mc_cnt [0:7]  = '{32'd5, 32'd4, 32'd3, 32'd2, 32'd1, 32'd0, 32'd0, 32'd0};

  always #5 clk = ~clk;

  timer_dev #(.BASE_ADDR(32'h0000_7F00)) dut (
    .clk    (clk),
    .reset  (reset),
    .addr   (addr),
    .byteen (byteen),
    .wdata  (wdata),
    .rdata  (rdata),
    .irq    (irq)
  );

  // Monitor: compare DUT outputs against the scoreboard head
  always @(negedge clk) begin
    if (chk_valid) begin
      if (sb_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL sb_underflow: sample flagged but no expectation queued");
      end else begin
        mon_e = sb_q.pop_front();
        if (mon_e.do_rd) begin
          checks++;
          if (rdata !== mon_e.exp_rd) begin
            failures++;
            $display("FAIL rdata tag=%0d addr=%h got=%h exp=%h", mon_e.tag, addr, rdata, mon_e.exp_rd);
          end
        end
        if (mon_e.do_irq) begin
          checks++;
          if (irq !== mon_e.exp_irq) begin
            failures++;
            $display("FAIL irq tag=%0d got=%b exp=%b", mon_e.tag, irq, mon_e.exp_irq);
          end
        end
      end
    end
  end

  // One bus cycle: drive inputs, optionally queue an expectation, pass one edge
  task automatic step(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be,
                      input logic drd, input logic [31:0] erd,
                      input logic dirq, input logic eirq, input int tag);
    addr   = a;
    wdata  = d;
    byteen = be;
    if (drd || dirq) begin
      sb_q.push_back('{exp_rd: erd, exp_irq: eirq, do_rd: drd, do_irq: dirq, tag: tag});
      chk_valid = 1'b1;
    end else begin
      chk_valid = 1'b0;
    end
    @(posedge clk);
    #1;
    chk_valid = 1'b0;
    byteen    = 4'b0000;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
    step(a, d, be, 1'b0, 32'd0, 1'b0, 1'b0, 0);
  endtask

  task automatic rd(input logic [31:0] a, input logic [31:0] e, input int tag);
    step(a, 32'd0, 4'b0000, 1'b1, e, 1'b0, 1'b0, tag);
  endtask

  task automatic rdi(input logic [31:0] a, input logic [31:0] e, input logic ei, input int tag);
    step(a, 32'd0, 4'b0000, 1'b1, e, 1'b1, ei, tag);
  endtask

  task automatic irqc(input logic ei, input int tag);
    step(A_RSV, 32'd0, 4'b0000, 1'b0, 32'd0, 1'b1, ei, tag);
  endtask

  task automatic idle();
    step(A_RSV, 32'd0, 4'b0000, 1'b0, 32'd0, 1'b0, 1'b0, 0);
  endtask

  initial begin
    reset  = 1'b1;
    addr   = 32'd0;
    wdata  = 32'd0;
    byteen = 4'b0000;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;

    // Reset values, reserved offset and a neighbouring non-hit address
    rdi(A_CTRL, 32'd0, 1'b0, 1);
    rd(A_PRE, 32'd0, 2);
    rd(A_CNT, 32'd0, 3);
    rd(A_RSV, 32'd0, 4);
    rd(32'h0000_7F10, 32'd0, 5);
    wr(32'h0000_7F14, 32'hFFFF_FFFF, BE_ALL);
    rd(A_PRE, 32'd0, 6);

    // One-shot: PRESET=3, CTRL=9 committed at edge t
    wr(A_PRE, 32'd3, BE_ALL);
    wr(A_CTRL, 32'h9, BE_ALL);
    rdi(A_CNT, 32'd0, 1'b0, 100);   // t   IDLE
    rdi(A_CNT, 32'd0, 1'b0, 101);   // t+1 LOAD
    rdi(A_CNT, 32'd3, 1'b0, 102);   // t+2
    rdi(A_CNT, 32'd2, 1'b0, 103);
    rdi(A_CNT, 32'd1, 1'b0, 104);
    rdi(A_CNT, 32'd0, 1'b0, 105);   // t+5
    rdi(A_CNT, 32'd0, 1'b1, 106);   // t+6 INT
    rdi(A_CTRL, 32'h8, 1'b1, 107);  // t+7 EN cleared
    rdi(A_CTRL, 32'h8, 1'b1, 108);
    irqc(1'b1, 109);
    wr(A_CTRL, 32'h0, BE_ALL);
    rdi(A_CTRL, 32'h0, 1'b0, 110);
    wr(A_CTRL, 32'h8, BE_ALL);      // flag must be gone, not just masked
    rdi(A_CTRL, 32'h8, 1'b0, 111);
    wr(A_CTRL, 32'h0, BE_ALL);

    // Auto-reload: PRESET=2, CTRL=B; one-cycle irq every 5 cycles
    wr(A_PRE, 32'd2, BE_ALL);
    wr(A_CTRL, 32'hB, BE_ALL);
    for (int k = 0; k < 13; k++)
      rdi(A_CNT, ar_cnt[k], (k == 5 || k == 10), 200 + k);
    wr(A_CTRL, 32'h3, BE_ALL);      // IM=0: irq stays low
    for (int k = 0; k < 10; k++)
      irqc(1'b0, 300 + k);
    wr(A_CTRL, 32'h0, BE_ALL);
    repeat (3) idle();

    // Mid-count PRESET change then stop
    wr(A_PRE, 32'd10, BE_ALL);
    wr(A_CTRL, 32'h3, BE_ALL);
    idle();
    idle();
    for (int k = 2; k < 6; k++)
      rd(A_CNT, 32'(12 - k), 400 + k);
    wr(A_PRE, 32'd4, BE_ALL);       // count 6 -> 5 at this edge
    for (int k = 0; k < 8; k++)
      rd(A_CNT, mc_cnt[k], 410 + k);
    wr(A_CTRL, 32'h0, BE_ALL);      // reloaded 4 -> 3 at this edge, then freeze
    rd(A_CNT, 32'd3, 420);
    rd(A_CNT, 32'd3, 421);
    rd(A_CNT, 32'd3, 422);
    rd(A_CTRL, 32'h0, 423);
    wr(A_CNT, 32'h1234_5678, BE_ALL);
    rd(A_CNT, 32'd3, 424);
    rd(A_PRE, 32'd4, 425);

    // PRESET=0: INT one cycle after LOAD; CTRL write in INT wins and clears flag
    wr(A_PRE, 32'd0, BE_ALL);
    wr(A_CTRL, 32'h9, BE_ALL);
    rdi(A_CNT, 32'd3, 1'b0, 500);
    rdi(A_CNT, 32'd3, 1'b0, 501);
    rdi(A_CNT, 32'd0, 1'b0, 502);
    step(A_CTRL, 32'h9, BE_ALL, 1'b0, 32'd0, 1'b1, 1'b1, 503);
    rdi(A_CTRL, 32'h9, 1'b0, 504);
    wr(A_CTRL, 32'h0, BE_ALL);
    repeat (3) idle();
    rdi(A_CTRL, 32'h0, 1'b0, 505);

    // Reset while COUNT=7
    wr(A_PRE, 32'd20, BE_ALL);
    wr(A_CTRL, 32'h9, BE_ALL);
    repeat (15) idle();
    reset = 1'b1;
    rd(A_CNT, 32'd7, 600);
    reset = 1'b0;
    rdi(A_CTRL, 32'h0, 1'b0, 601);
    rd(A_PRE, 32'd0, 602);
    rd(A_CNT, 32'd0, 603);
    rd(A_CNT, 32'd0, 604);

    // Byte enables
    wr(A_PRE, 32'hAABB_CCDD, 4'b0011);
    rd(A_PRE, PARTIAL_PRE, 700);
    wr(A_PRE, 32'hAABB_CCDD, BE_ALL);
    rd(A_PRE, 32'hAABB_CCDD, 701);
    wr(A_PRE, 32'd0, BE_ALL);
    wr(A_CTRL, 32'h9, BE_ALL);
    repeat (3) idle();
    irqc(1'b1, 702);
    rdi(A_CTRL, 32'h8, 1'b1, 703);
    wr(A_CTRL, 32'h0, 4'b1110);     // lane 0 untouched: no change, no clear
    rdi(A_CTRL, 32'h8, 1'b1, 704);
    wr(A_CTRL, 32'h0, 4'b0001);
    rdi(A_CTRL, LANE0_CTRL, LANE0_IRQ, 705);
    wr(A_CTRL, 32'h0, BE_ALL);
    rdi(A_CTRL, 32'h0, 1'b0, 706);

    idle();
    checks++;
    if (sb_q.size() != 0) begin
      failures++;
      $display("FAIL sb_leftover: %0d expectations never sampled, exp 0", sb_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
